// File: rtl/distinct_hash_nway_pkg.sv
// Shared types and helpers for the DISTINCT hash engine.
// Mode/FSM enums and the XOR-fold bucket hash.
package distinct_hash_nway_pkg;

    typedef enum logic {
        DIST_MARK,
        DIST_FILTER
    } dist_mode_t;

    typedef enum logic [1:0] {
        ST_SWEEP,
        ST_IDLE,
        ST_DRAIN
    } dist_fsm_t;

    // Bit i of the key lands in hash bit (i mod hbits).
    // Equivalent to XOR of hbits-wide chunks.
    // The top chunk is implicitly zero-padded.
    function automatic logic [31:0] dist_hash(
        input logic [63:0] key,
        input int          hbits
    );
        logic [31:0] r;
        logic [4:0]  j;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            j    = 5'(i % hbits);
            r[j] = r[j] ^ key[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/distinct_hash_nway_bucket_ram.sv
// Simple dual-port bucket RAM, one write and one read port.
// Registered read, one cycle latency, contents not reset.
module distinct_bucket_ram #(
    parameter int AW = 10,
    parameter int DW = 132
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    // write port
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // read port
    always_ff @(posedge clk) begin
        if (re)
            rd <= mem[ra];
    end

endmodule

// File: rtl/distinct_hash_nway.sv
// N-way set-associative DISTINCT engine, one key per cycle.
// Hazard forwarding, overflow count, drain+sweep clear, MARK/FILTER output.
module distinct_hash_nway
    import distinct_hash_nway_pkg::*;
#(
    parameter int KEY_BITS = 32,
    parameter int DEPTH    = 1024,
    parameter int WAYS     = 4,
    parameter int QDEPTH   = 16,
    parameter int MODE     = 0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [KEY_BITS-1:0] s_key,
    input  logic                s_last,
    input  logic                s_hit,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [KEY_BITS-1:0] m_key,
    output logic                m_last,
    output logic                m_hit,
    input  logic                clear,
    output logic                busy,
    output logic [31:0]         stat_uniq,
    output logic [31:0]         stat_dup,
    output logic [31:0]         stat_ovf
);

    localparam int HBITS = $clog2(DEPTH);
    localparam int EW    = KEY_BITS + 1;
    localparam int RW    = WAYS * EW;
    localparam int QA    = $clog2(QDEPTH);
    localparam int CW    = QA + 1;
    localparam int FW    = KEY_BITS + 2;
    localparam bit FILT  = (MODE == int'(DIST_FILTER));

    dist_fsm_t           st;
    logic [HBITS-1:0]    sptr;

    logic                acc;
    logic [HBITS-1:0]    h;
    logic [RW-1:0]       ram_rd;
    logic                ram_we;
    logic [HBITS-1:0]    ram_wa;
    logic [RW-1:0]       ram_wd;

    logic                s1_v, s1_last, s1_hit, s1_byp;
    logic [KEY_BITS-1:0] s1_key;
    logic [HBITS-1:0]    s1_b;
    logic [RW-1:0]       s1_brow, s1_row, s1_eff;

    logic                s2_v, s2_last, s2_hit;
    logic [KEY_BITS-1:0] s2_key;
    logic [HBITS-1:0]    s2_b;
    logic [RW-1:0]       s2_row, wrow;
    logic                any_m, ffree, hitf, we2, ovf2;
    int                  fidx;

    logic [FW-1:0]       fmem [QDEPTH];
    logic [QA-1:0]       wp, rp;
    logic [CW-1:0]       cnt, cred;
    logic                push, pop;

    assign h   = HBITS'(dist_hash(64'(s_key), HBITS));
    assign acc = s_valid & s_ready;

    assign busy    = (st != ST_IDLE);
    assign cred    = CW'(QDEPTH) - cnt - CW'(s1_v) - CW'(s2_v);
    assign s_ready = (st == ST_IDLE) && (cred != '0);

    assign ram_we = (st == ST_SWEEP) | we2;
    assign ram_wa = (st == ST_SWEEP) ? sptr : s2_b;
    assign ram_wd = (st == ST_SWEEP) ? '0 : wrow;

    distinct_bucket_ram #(
        .AW (HBITS),
        .DW (RW)
    ) u_ram (
        .clk (aclk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .re  (acc),
        .ra  (h),
        .rd  (ram_rd)
    );

    // S1 row: same-cycle write bypass, then patch from the S2 write
    always_comb begin
        s1_row = s1_byp ? s1_brow : ram_rd;
        s1_eff = (we2 && (s2_b == s1_b)) ? wrow : s1_row;
    end

    // S2 compare, lowest free way, and the updated bucket row
    always_comb begin
        any_m = 1'b0;
        ffree = 1'b0;
        fidx  = 0;
        wrow  = s2_row;
        for (int w = 0; w < WAYS; w++)
            if (s2_row[w*EW+KEY_BITS] &&
                s2_row[w*EW +: KEY_BITS] == s2_key)
                any_m = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!s2_row[w*EW+KEY_BITS]) begin
                ffree = 1'b1;
                fidx  = w;
            end
        for (int w = 0; w < WAYS; w++)
            if (ffree && w == fidx)
                wrow[w*EW +: EW] = {1'b1, s2_key};
        hitf = any_m | s2_hit;
        we2  = s2_v & ~hitf & ffree;
        ovf2 = s2_v & ~hitf & ~ffree;
    end

    // pipeline registers S0->S1->S2
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_v    <= 1'b0;
            s1_key  <= '0;
            s1_last <= 1'b0;
            s1_hit  <= 1'b0;
            s1_b    <= '0;
            s1_byp  <= 1'b0;
            s1_brow <= '0;
            s2_v    <= 1'b0;
            s2_key  <= '0;
            s2_last <= 1'b0;
            s2_hit  <= 1'b0;
            s2_b    <= '0;
            s2_row  <= '0;
        end else begin
            s1_v    <= acc;
            s1_key  <= s_key;
            s1_last <= s_last;
            s1_hit  <= s_hit;
            s1_b    <= h;
            s1_byp  <= we2 && (s2_b == h);
            s1_brow <= wrow;
            s2_v    <= s1_v;
            s2_key  <= s1_key;
            s2_last <= s1_last;
            s2_hit  <= s1_hit;
            s2_b    <= s1_b;
            s2_row  <= s1_eff;
        end
    end

    // clear/init FSM: sweep one bucket per cycle, drain before sweeping
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st   <= ST_SWEEP;
            sptr <= '0;
        end else begin
            unique case (st)
                ST_SWEEP: begin
                    sptr <= sptr + 1'b1;
                    if (sptr == HBITS'(DEPTH - 1))
                        st <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (clear)
                        st <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!s1_v && !s2_v) begin
                        st   <= ST_SWEEP;
                        sptr <= '0;
                    end
                end
                default: st <= ST_SWEEP;
            endcase
        end
    end

    // saturating statistics, zeroed when a sweep begins
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_uniq <= '0;
            stat_dup  <= '0;
            stat_ovf  <= '0;
        end else if (st == ST_DRAIN && !s1_v && !s2_v) begin
            stat_uniq <= '0;
            stat_dup  <= '0;
            stat_ovf  <= '0;
        end else begin
            if (we2 && stat_uniq != '1)
                stat_uniq <= stat_uniq + 32'd1;
            if (s2_v && hitf && stat_dup != '1)
                stat_dup <= stat_dup + 32'd1;
            if (ovf2 && stat_ovf != '1)
                stat_ovf <= stat_ovf + 32'd1;
        end
    end

    assign push    = s2_v & (!FILT | ~hitf | s2_last);
    assign m_valid = (cnt != '0);
    assign pop     = m_valid & m_ready;
    assign {m_key, m_last, m_hit} = fmem[rp];

    // output queue storage
    always_ff @(posedge aclk) begin
        if (push)
            fmem[wp] <= {s2_key, s2_last, hitf};
    end

    // output queue pointers and occupancy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_distinct_hash_nway.sv
// Scoreboard bench for distinct_hash_nway, MARK and FILTER side by side.
// Both instances see the same accepted stream; a table model predicts.
module tb_distinct_hash_nway;

    localparam int KB    = 32;
    localparam int DEPTH = 64;
    localparam int WAYS  = 4;
    localparam int QD    = 16;
    localparam int HB    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_last, s_hit, m_ready, clear;
    logic [KB-1:0] s_key;

    logic          s_ready_a, m_valid_a, m_last_a, m_hit_a, busy_a;
    logic [KB-1:0] m_key_a;
    logic [31:0]   uniq_a, dup_a, ovf_a;
    logic          s_ready_b, m_valid_b, m_last_b, m_hit_b, busy_b;
    logic [KB-1:0] m_key_b;
    logic [31:0]   uniq_b, dup_b, ovf_b;

    int checks = 0;
    int failures = 0;

    logic [31:0] tk [DEPTH*WAYS];
    int          tn [DEPTH];
    int unsigned mu, md, mo;
    logic [33:0] q0[$], q1[$], log0[$], log1[$];
    bit          rnd_mr = 1'b0;

    distinct_hash_nway #(
        .KEY_BITS(KB), .DEPTH(DEPTH), .WAYS(WAYS), .QDEPTH(QD), .MODE(0)
    ) u_mark (
        .aclk(clk), .aresetn(rst_n),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_key(s_key),
        .s_last(s_last), .s_hit(s_hit),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_key(m_key_a),
        .m_last(m_last_a), .m_hit(m_hit_a),
        .clear(clear), .busy(busy_a),
        .stat_uniq(uniq_a), .stat_dup(dup_a), .stat_ovf(ovf_a)
    );

    distinct_hash_nway #(
        .KEY_BITS(KB), .DEPTH(DEPTH), .WAYS(WAYS), .QDEPTH(QD), .MODE(1)
    ) u_filt (
        .aclk(clk), .aresetn(rst_n),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_key(s_key),
        .s_last(s_last), .s_hit(s_hit),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_key(m_key_b),
        .m_last(m_last_b), .m_hit(m_hit_b),
        .clear(clear), .busy(busy_b),
        .stat_uniq(uniq_b), .stat_dup(dup_b), .stat_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int mhash(input logic [31:0] k);
        logic [31:0] hv;
        hv = '0;
        for (int s = 0; s < 32; s += HB)
            hv ^= (k >> s) & ((32'd1 << HB) - 1);
        return int'(hv);
    endfunction

    task automatic model_accept(input logic [31:0] k, input logic l,
                                input logic sh);
        int  b;
        bit  found, hit;
        b = mhash(k);
        found = 0;
        for (int i = 0; i < tn[b]; i++)
            if (tk[b*WAYS+i] == k) found = 1;
        hit = found | sh;
        if (hit) md++;
        else if (tn[b] < WAYS) begin
            tk[b*WAYS+tn[b]] = k;
            tn[b]++;
            mu++;
        end else mo++;
        q0.push_back({k, l, hit});
        if (!hit || l) q1.push_back({k, l, hit});
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) tn[i] = 0;
        mu = 0; md = 0; mo = 0;
    endtask

    // monitor: pop expected on each output handshake, log actuals
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && m_valid_a && m_ready) begin
            log0.push_back({m_key_a, m_last_a, m_hit_a});
            if (q0.size() == 0) chk("mark_extra", 1, 0);
            else begin
                e = q0.pop_front();
                chk("mark_out", {m_key_a, m_last_a, m_hit_a}, e);
            end
        end
        if (rst_n && m_valid_b && m_ready) begin
            log1.push_back({m_key_b, m_last_b, m_hit_b});
            if (q1.size() == 0) chk("filt_extra", 1, 0);
            else begin
                e = q1.pop_front();
                chk("filt_out", {m_key_b, m_last_b, m_hit_b}, e);
            end
        end
        if (rst_n && s_valid)
            model_accept(s_key, s_last, s_hit);
    end

    // random output backpressure
    always @(posedge clk) begin
        if (rnd_mr) begin
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] k, input logic l,
                        input logic sh);
        for (int i = 0; i < 4 * DEPTH + 64; i++) begin
            if (s_ready_a && s_ready_b) begin
                s_valid = 1'b1;
                s_key   = k;
                s_last  = l;
                s_hit   = sh;
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_uniq"}, uniq_a, mu);
        chk({nm, "_dup"}, dup_a, md);
        chk({nm, "_ovf"}, ovf_a, mo);
        chk({nm, "_uniq_f"}, uniq_b, mu);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int n, nacc, base;
        rst_n = 1'b0; s_valid = 0; s_key = '0; s_last = 0;
        s_hit = 0; m_ready = 1'b1; clear = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid_a, 0);
        chk("rst_s_ready", s_ready_a, 0);
        chk("rst_busy", busy_a, 1);
        chk("rst_stats", {uniq_a, dup_a}, 0);
        chk("rst_ovf", ovf_b, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // init sweep length
        n = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            if (s_ready_a) break;
            if (busy_a) n++;
        end
        chk("init_busy_cycles", n, DEPTH);
        chk("init_busy_low", busy_a, 0);
        chk("init_ready_f", s_ready_b, 1);
        @(posedge clk);
        #1;

        // MARK 5,9,5,5(last)
        log0.delete(); log1.delete();
        send(5, 0, 0); send(9, 0, 0); send(5, 0, 0); send(5, 1, 0);
        idle(8);
        chk("t2_n", log0.size(), 4);
        if (log0.size() == 4) begin
            chk("t2_h0", log0[0][0], 0);
            chk("t2_h1", log0[1][0], 0);
            chk("t2_h2", log0[2][0], 1);
            chk("t2_h3", log0[3][0], 1);
        end
        chk("t2_filt_n", log1.size(), 3);
        chk("t2_uniq", uniq_a, 2);
        chk("t2_dup", dup_a, 2);

        // hazards: back-to-back and one-gap same bucket
        log0.delete();
        send(32'h77, 0, 0); send(32'h77, 0, 0);
        send(32'h33, 0, 0); send(32'h34, 0, 0); send(32'h33, 0, 0);
        idle(8);
        chk("t3_n", log0.size(), 5);
        if (log0.size() == 5) begin
            chk("t3_h0", log0[0][0], 0);
            chk("t3_h1", log0[1][0], 1);
            chk("t3_h4", log0[4][0], 1);
        end
        base = ovf_a;
        for (int c = 4; c < 7; c++)
            send((c << 6) | (c ^ 54), 0, 0);
        idle(6);
        chk("t3_single_entry", ovf_a, base);

        // bucket overflow in bucket 17
        log0.delete();
        for (int c = 1; c < 7; c++)
            send((c << 6) | (c ^ 17), 0, 0);
        idle(8);
        chk("t4_n", log0.size(), 6);
        for (int i = 0; i < 6 && i < log0.size(); i++)
            chk("t4_miss", log0[i][0], 0);
        chk("t4_ovf", ovf_a, 2);
        log0.delete();
        send((5 << 6) | (5 ^ 17), 0, 0);
        send((1 << 6) | (1 ^ 17), 0, 0);
        idle(8);
        chk("t4_replay_n", log0.size(), 2);
        if (log0.size() == 2) begin
            chk("t4_replay5", log0[0][0], 0);
            chk("t4_replay1", log0[1][0], 1);
        end
        chk("t4_ovf2", ovf_a, 3);
        chk_stats("t4");

        // FILTER 1,2,1,2(last)
        log1.delete();
        base = dup_b;
        send(1, 0, 0); send(2, 0, 0); send(1, 0, 0); send(2, 1, 0);
        idle(8);
        chk("t5_n", log1.size(), 3);
        if (log1.size() == 3) begin
            chk("t5_o0", log1[0], {32'd1, 2'b00});
            chk("t5_o1", log1[1], {32'd2, 2'b00});
            chk("t5_o2", log1[2], {32'd2, 2'b11});
        end
        chk("t5_dup", dup_b - base, 2);

        // FIFO full: only QD beats accepted with m_ready low
        m_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (s_ready_a && s_ready_b) begin
                s_valid = 1'b1;
                s_key = 1000 + nacc;
                s_last = 0; s_hit = 0;
                nacc++;
            end else s_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("full_accepted", nacc, QD);
        chk("full_ready_low", s_ready_a, 0);
        m_ready = 1'b1;
        idle(24);

        // clear with beats in flight and output stalled
        log0.delete();
        m_ready = 1'b0;
        send(10, 0, 0); send(11, 0, 0); send(12, 1, 0);
        clear = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        clear = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
            clear = (n == 10);
        end
        clear = 1'b0;
        chk("t6_busy_lo", n >= DEPTH + 1, 1);
        chk("t6_busy_hi", n <= DEPTH + 4, 1);
        chk("t6_fifo_held", m_valid_a, 1);
        @(posedge clk);
        #1;
        chk("t6_stats", {uniq_a, dup_a}, 0);
        chk_stats("t6");
        m_ready = 1'b1;
        send(1, 0, 0);
        idle(8);
        chk("t6_n", log0.size(), 4);
        if (log0.size() == 4) begin
            chk("t6_k0", log0[0][33:2], 10);
            chk("t6_k2", log0[2][33:2], 12);
            chk("t6_replay", log0[3], {32'd1, 2'b00});
        end

        // randomized traffic with backpressure and one clear
        rnd_mr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] k;
            k = ($urandom_range(0, 3) == 0) ? $urandom
                                            : $urandom_range(0, 150);
            send(k, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) idle(1);
            if (i == 200 && !busy_a) begin
                clear = 1'b1;
                model_clear();
                @(posedge clk);
                #1;
                clear = 1'b0;
            end
        end
        rnd_mr = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        idle(40);
        chk_stats("rand");
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
